// File: rtl/noc_pkt.sv
// Shared NoC packet encodings and default field widths.
package noc_pkt;

  localparam int unsigned DEF_TYPE_W = 3;
  localparam int unsigned DEF_DEST_W = 8;
  localparam int unsigned DEF_NHOP_W = 5;
  localparam int unsigned DEF_RID_W  = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic [DEF_TYPE_W-1:0] TYPE_REQUEST     = 3'd1;
  localparam logic [DEF_TYPE_W-1:0] TYPE_OUTSTANDING = 3'd3;
  localparam logic [DEF_TYPE_W-1:0] TYPE_C_REQ       = 3'd4;

endpackage

// File: rtl/hitmux_pipe_lane.sv
// One channel of the directory-hit rewrite mux: header decode, one output
// register stage behind valid/ready, and saturating hit/memory counters.
module hitmux_lane
  import noc_pkt::*;
#(
  parameter int unsigned DEST_W            = DEF_DEST_W,
  parameter int unsigned NHOP_W            = DEF_NHOP_W,
  parameter int unsigned RID_W             = DEF_RID_W,
  parameter int unsigned TYPE_W            = DEF_TYPE_W,
  parameter int unsigned CNT_W             = DEF_CNT_W,
  parameter int unsigned ROUTER_ID         = 0,
  parameter int unsigned NUM_COMPUTE_NODES = 16,
  parameter int unsigned MEM_ADDRESS       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bypass,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [RID_W-1:0]  in_rid,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [NHOP_W-1:0] in_nhop,
  input  logic              dir_hit,
  input  logic [DEST_W-1:0] dir_dest,
  input  logic [NHOP_W-1:0] dir_nhop,
  input  logic [NHOP_W-1:0] mem_nhop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TYPE_W-1:0] out_type,
  output logic [DEST_W-1:0] out_dest,
  output logic [NHOP_W-1:0] out_nhop,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  mem_cnt
);

  localparam logic [RID_W-1:0]  OWN_RID   = RID_W'(ROUTER_ID);
  // Home-memory address of this router, truncated to the dest width.
  localparam logic [DEST_W-1:0] HOME_DEST = DEST_W'(ROUTER_ID + NUM_COMPUTE_NODES);
  localparam logic [DEST_W-1:0] MEM_DEST  = DEST_W'(MEM_ADDRESS);
  localparam logic [TYPE_W-1:0] T_REQ     = TYPE_W'(TYPE_REQUEST);
  localparam logic [TYPE_W-1:0] T_OUTST   = TYPE_W'(TYPE_OUTSTANDING);
  localparam logic [TYPE_W-1:0] T_CREQ    = TYPE_W'(TYPE_C_REQ);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic              is_outst, is_redir, accept;
  logic              valid_q, valid_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [NHOP_W-1:0] nhop_q, nhop_d;
  logic [CNT_W-1:0]  hit_q, hit_d, mem_q, mem_d;

  assign is_outst = (in_type == T_OUTST) && (in_rid == OWN_RID) && dir_hit;
  assign is_redir = (in_type == T_REQ) && (in_rid == OWN_RID) && (in_dest == HOME_DEST);

  // Header rewrite; bypass or a non-matching header passes through untouched.
  always_comb begin
    type_d = in_type;
    dest_d = in_dest;
    nhop_d = in_nhop;
    if (!bypass) begin
      if (is_outst) begin
        nhop_d = dir_nhop;
      end else if (is_redir) begin
        if (dir_hit) begin
          type_d = T_CREQ;
          dest_d = dir_dest;
          nhop_d = dir_nhop;
        end else begin
          dest_d = MEM_DEST;
          nhop_d = mem_nhop;
        end
      end
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output valid: set on accept, cleared once the held header drains.
  always_comb begin
    valid_d = valid_q;
    if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_comb begin
    hit_d = hit_q;
    mem_d = mem_q;
    if (cnt_clr) begin
      hit_d = '0;
      mem_d = '0;
    end else if (accept && !bypass && is_redir) begin
      if (dir_hit && hit_q != CNT_MAX) hit_d = hit_q + CNT_W'(1);
      if (!dir_hit && mem_q != CNT_MAX) mem_d = mem_q + CNT_W'(1);
    end
  end

  // Pipeline register and counters with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      type_q  <= '0;
      dest_q  <= '0;
      nhop_q  <= '0;
      hit_q   <= '0;
      mem_q   <= '0;
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      mem_q   <= mem_d;
      if (accept) begin
        type_q <= type_d;
        dest_q <= dest_d;
        nhop_q <= nhop_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_type  = type_q;
  assign out_dest  = dest_q;
  assign out_nhop  = nhop_q;
  assign hit_cnt   = hit_q;
  assign mem_cnt   = mem_q;

endmodule

// File: rtl/hitmux_pipe.sv
// Registered directory-hit rewrite mux: NUM_CH independent lanes, bus slicing only.
module hitmux_pipe
  import noc_pkt::*;
#(
  parameter int unsigned NUM_CH            = 5,
  parameter int unsigned DEST_W            = DEF_DEST_W,
  parameter int unsigned NHOP_W            = DEF_NHOP_W,
  parameter int unsigned RID_W             = DEF_RID_W,
  parameter int unsigned TYPE_W            = DEF_TYPE_W,
  parameter int unsigned CNT_W             = DEF_CNT_W,
  parameter int unsigned ROUTER_ID         = 0,
  parameter int unsigned NUM_COMPUTE_NODES = 16,
  parameter int unsigned MEM_ADDRESS       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bypass,
  input  logic                     cnt_clr,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*TYPE_W-1:0] in_type,
  input  logic [NUM_CH*RID_W-1:0]  in_rid,
  input  logic [NUM_CH*DEST_W-1:0] in_dest,
  input  logic [NUM_CH*NHOP_W-1:0] in_nhop,
  input  logic [NUM_CH-1:0]        dir_hit,
  input  logic [NUM_CH*DEST_W-1:0] dir_dest,
  input  logic [NUM_CH*NHOP_W-1:0] dir_nhop,
  input  logic [NUM_CH*NHOP_W-1:0] mem_nhop,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*TYPE_W-1:0] out_type,
  output logic [NUM_CH*DEST_W-1:0] out_dest,
  output logic [NUM_CH*NHOP_W-1:0] out_nhop,
  output logic [NUM_CH*CNT_W-1:0]  hit_cnt,
  output logic [NUM_CH*CNT_W-1:0]  mem_cnt
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    hitmux_lane #(
      .DEST_W           (DEST_W),
      .NHOP_W           (NHOP_W),
      .RID_W            (RID_W),
      .TYPE_W           (TYPE_W),
      .CNT_W            (CNT_W),
      .ROUTER_ID        (ROUTER_ID),
      .NUM_COMPUTE_NODES(NUM_COMPUTE_NODES),
      .MEM_ADDRESS      (MEM_ADDRESS)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .bypass   (bypass),
      .cnt_clr  (cnt_clr),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_type  (in_type[g*TYPE_W +: TYPE_W]),
      .in_rid   (in_rid[g*RID_W +: RID_W]),
      .in_dest  (in_dest[g*DEST_W +: DEST_W]),
      .in_nhop  (in_nhop[g*NHOP_W +: NHOP_W]),
      .dir_hit  (dir_hit[g]),
      .dir_dest (dir_dest[g*DEST_W +: DEST_W]),
      .dir_nhop (dir_nhop[g*NHOP_W +: NHOP_W]),
      .mem_nhop (mem_nhop[g*NHOP_W +: NHOP_W]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_type (out_type[g*TYPE_W +: TYPE_W]),
      .out_dest (out_dest[g*DEST_W +: DEST_W]),
      .out_nhop (out_nhop[g*NHOP_W +: NHOP_W]),
      .hit_cnt  (hit_cnt[g*CNT_W +: CNT_W]),
      .mem_cnt  (mem_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_hitmux_pipe.sv
// Bench for hitmux_pipe: per-cycle behavioural model plus directed literal checks.
module tb_hitmux_pipe;

  localparam int NCH  = 5;
  localparam int DW   = 8;
  localparam int NW   = 5;
  localparam int RW   = 8;
  localparam int TW   = 3;
  localparam int CW   = 4;
  localparam int RID  = 3;
  localparam int NCN  = 16;
  localparam int MEM  = 0;
  localparam int CMAX = (1 << CW) - 1;
  localparam int HOME = (RID + NCN) % (1 << DW);
  localparam int T_REQ = 1, T_OUT = 3, T_CREQ = 4;

  logic clk = 1'b0;
  logic rst, bypass, cnt_clr;
  logic [NCH-1:0]    in_valid, in_ready, dir_hit, out_valid, out_ready;
  logic [NCH*TW-1:0] in_type, out_type;
  logic [NCH*RW-1:0] in_rid;
  logic [NCH*DW-1:0] in_dest, dir_dest, out_dest;
  logic [NCH*NW-1:0] in_nhop, dir_nhop, mem_nhop, out_nhop;
  logic [NCH*CW-1:0] hit_cnt, mem_cnt;

  // Per-channel stimulus, packed onto the buses below.
  int s_type [NCH], s_rid [NCH], s_dest [NCH], s_nhop [NCH];
  int s_ddest[NCH], s_dnhop[NCH], s_mnhop[NCH];

  always_comb begin
    in_type = '0; in_rid = '0; in_dest = '0; in_nhop = '0;
    dir_dest = '0; dir_nhop = '0; mem_nhop = '0;
    for (int i = 0; i < NCH; i++) begin
      in_type[i*TW +: TW]  = TW'(s_type[i]);
      in_rid[i*RW +: RW]   = RW'(s_rid[i]);
      in_dest[i*DW +: DW]  = DW'(s_dest[i]);
      in_nhop[i*NW +: NW]  = NW'(s_nhop[i]);
      dir_dest[i*DW +: DW] = DW'(s_ddest[i]);
      dir_nhop[i*NW +: NW] = NW'(s_dnhop[i]);
      mem_nhop[i*NW +: NW] = NW'(s_mnhop[i]);
    end
  end

  hitmux_pipe #(
    .NUM_CH(NCH), .DEST_W(DW), .NHOP_W(NW), .RID_W(RW), .TYPE_W(TW), .CNT_W(CW),
    .ROUTER_ID(RID), .NUM_COMPUTE_NODES(NCN), .MEM_ADDRESS(MEM)
  ) dut (
    .clk(clk), .rst(rst), .bypass(bypass), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_rid(in_rid),
    .in_dest(in_dest), .in_nhop(in_nhop), .dir_hit(dir_hit), .dir_dest(dir_dest),
    .dir_nhop(dir_nhop), .mem_nhop(mem_nhop), .out_valid(out_valid),
    .out_ready(out_ready), .out_type(out_type), .out_dest(out_dest),
    .out_nhop(out_nhop), .hit_cnt(hit_cnt), .mem_cnt(mem_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input int ch, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s ch%0d got=0x%0h want=0x%0h at %0t", name, ch, act, exp, $time);
    end
  endtask

  function automatic int o_type(input int c); return int'(out_type[c*TW +: TW]); endfunction
  function automatic int o_dest(input int c); return int'(out_dest[c*DW +: DW]); endfunction
  function automatic int o_nhop(input int c); return int'(out_nhop[c*NW +: NW]); endfunction
  function automatic int o_hit(input int c);  return int'(hit_cnt[c*CW +: CW]); endfunction
  function automatic int o_mem(input int c);  return int'(mem_cnt[c*CW +: CW]); endfunction

  // ---------------- behavioural model ----------------
  // kind: 0 = no count, 1 = redirect to directory, 2 = redirect to memory
  typedef struct { int t; int d; int n; int kind; } rw_t;

  function automatic rw_t rewrite(input int c, input bit byp);
    rw_t r;
    r.t = s_type[c]; r.d = s_dest[c]; r.n = s_nhop[c]; r.kind = 0;
    if (byp) return r;
    if (s_type[c] == T_OUT && s_rid[c] == RID && dir_hit[c]) begin
      r.n = s_dnhop[c];
    end else if (s_type[c] == T_REQ && s_rid[c] == RID && s_dest[c] == HOME) begin
      if (dir_hit[c]) begin
        r.t = T_CREQ; r.d = s_ddest[c]; r.n = s_dnhop[c]; r.kind = 1;
      end else begin
        r.d = MEM; r.n = s_mnhop[c]; r.kind = 2;
      end
    end
    return r;
  endfunction

  bit m_v [NCH];
  int m_t [NCH], m_d [NCH], m_n [NCH], m_hc [NCH], m_mc [NCH];

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_v[i] = 0; m_t[i] = 0; m_d[i] = 0; m_n[i] = 0; m_hc[i] = 0; m_mc[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst) begin
        m_v[i] = 0; m_t[i] = 0; m_d[i] = 0; m_n[i] = 0; m_hc[i] = 0; m_mc[i] = 0;
      end else begin
        rw_t r;
        bit acc;
        r   = rewrite(i, bypass);
        acc = in_valid[i] && (!m_v[i] || out_ready[i]);
        if (cnt_clr) begin
          m_hc[i] = 0; m_mc[i] = 0;
        end else if (acc) begin
          if (r.kind == 1 && m_hc[i] < CMAX) m_hc[i]++;
          if (r.kind == 2 && m_mc[i] < CMAX) m_mc[i]++;
        end
        if (acc) begin
          m_v[i] = 1; m_t[i] = r.t; m_d[i] = r.d; m_n[i] = r.n;
        end else if (out_ready[i]) begin
          m_v[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NCH; i++) begin
        cmp("out_valid", i, int'(out_valid[i]), int'(m_v[i]));
        cmp("in_ready", i, int'(in_ready[i]), int'(!m_v[i] || out_ready[i]));
        cmp("out_type", i, o_type(i), m_t[i]);
        cmp("out_dest", i, o_dest(i), m_d[i]);
        cmp("out_nhop", i, o_nhop(i), m_n[i]);
        cmp("hit_cnt", i, o_hit(i), m_hc[i]);
        cmp("mem_cnt", i, o_mem(i), m_mc[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hdr(input int c, input int t, input int r, input int d, input int n,
                     input bit h, input int dd, input int dn, input int mn);
    s_type[c] = t; s_rid[c] = r; s_dest[c] = d; s_nhop[c] = n;
    dir_hit[c] = h; s_ddest[c] = dd; s_dnhop[c] = dn; s_mnhop[c] = mn;
  endtask

  initial begin
    rst = 1'b0; bypass = 1'b0; cnt_clr = 1'b0;
    in_valid = '0; out_ready = '1; dir_hit = '0;
    for (int i = 0; i < NCH; i++) hdr(i, 0, 0, 0, 0, 1'b0, 0, 0, 0);

    // Reset and idle
    step(1);
    chk_en = 1'b1;
    step(1);
    cmp("rst_out_valid", 0, int'(out_valid), 0);
    cmp("rst_in_ready", 0, int'(in_ready), 'h1f);
    cmp("rst_out_dest", 0, int'(out_dest), 0);
    cmp("rst_hit_cnt", 0, int'(hit_cnt), 0);
    rst = 1'b1;
    step(2);
    cmp("idle_out_valid", 0, int'(out_valid), 0);

    // Redirect with directory hit
    hdr(0, T_REQ, 3, 19, 5'b00001, 1'b1, 'h2A, 5'b00100, 5'b10000);
    in_valid[0] = 1'b1;
    step(1);
    in_valid[0] = 1'b0;
    cmp("hit_type", 0, o_type(0), T_CREQ);
    cmp("hit_dest", 0, o_dest(0), 'h2A);
    cmp("hit_nhop", 0, o_nhop(0), 5'b00100);
    cmp("hit_cnt1", 0, o_hit(0), 1);

    // Redirect miss
    dir_hit[0] = 1'b0;
    in_valid[0] = 1'b1;
    step(1);
    in_valid[0] = 1'b0;
    cmp("miss_type", 0, o_type(0), T_REQ);
    cmp("miss_dest", 0, o_dest(0), 0);
    cmp("miss_nhop", 0, o_nhop(0), 5'b10000);
    cmp("miss_cnt", 0, o_mem(0), 1);

    // Outstanding: nhop from directory, no counting
    hdr(0, T_OUT, 3, 'h55, 5'b00001, 1'b1, 'h2A, 5'b00010, 5'b10000);
    in_valid[0] = 1'b1;
    step(1);
    in_valid[0] = 1'b0;
    cmp("outst_dest", 0, o_dest(0), 'h55);
    cmp("outst_nhop", 0, o_nhop(0), 5'b00010);
    cmp("outst_hit", 0, o_hit(0), 1);
    cmp("outst_mem", 0, o_mem(0), 1);

    // Backpressure on ch2 while ch1 streams
    out_ready[2] = 1'b0;
    hdr(2, 2, 7, 'h11, 5'b00001, 1'b0, 0, 0, 0);
    hdr(1, 2, 7, 'h40, 5'b01000, 1'b0, 0, 0, 0);
    in_valid[2] = 1'b1; in_valid[1] = 1'b1;
    step(1);
    for (int k = 0; k < 4; k++) begin
      s_dest[2] = 'h12 + k;
      s_dest[1] = 'h41 + k;
      step(1);
      cmp("bp_ready", 2, int'(in_ready[2]), 0);
      cmp("bp_hold", 2, o_dest(2), 'h11);
      cmp("bp_other", 1, o_dest(1), 'h41 + k);
    end
    out_ready[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_dest[2] = 'h20 + k;
      step(1);
      cmp("bp_flow", 2, o_dest(2), 'h20 + k);
    end
    in_valid[2] = 1'b0; in_valid[1] = 1'b0;
    step(1);

    // Bypass and non-matching router id
    bypass = 1'b1;
    hdr(3, T_REQ, 3, 19, 5'b00001, 1'b1, 'h2A, 5'b00100, 5'b10000);
    in_valid[3] = 1'b1;
    step(1);
    bypass = 1'b0;
    s_rid[3] = 4;
    cmp("byp_type", 3, o_type(3), T_REQ);
    cmp("byp_dest", 3, o_dest(3), 19);
    cmp("byp_cnt", 3, o_hit(3), 0);
    step(1);
    in_valid[3] = 1'b0;
    cmp("rid4_dest", 3, o_dest(3), 19);
    cmp("rid4_nhop", 3, o_nhop(3), 5'b00001);

    // Saturation, clear priority
    hdr(4, T_REQ, 3, 19, 5'b00001, 1'b1, 'h33, 5'b00010, 5'b10000);
    in_valid[4] = 1'b1;
    step(17);
    cmp("sat_cnt", 4, o_hit(4), 15);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    cmp("clr_cnt", 4, o_hit(4), 0);
    step(1);
    cmp("post_clr", 4, o_hit(4), 1);

    // Reset mid-transfer drops the held header
    out_ready[4] = 1'b0;
    step(1);
    cmp("held_valid", 4, int'(out_valid[4]), 1);
    rst = 1'b0;
    step(1);
    cmp("rst_mid_valid", 4, int'(out_valid[4]), 0);
    cmp("rst_mid_ready", 4, int'(in_ready), 'h1f);
    rst = 1'b1;
    in_valid = '0;
    out_ready = '1;
    step(2);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hitmux_pipe.md
Name: hitmux_pipe

Overview:
- Parametrised, registered successor of the directory-hit rewrite mux.
- Per channel: takes a packet header (type, router id, dest, next hop) with a directory lookup result (hit, dir dest, dir nhop) and a memory-route nhop, rewrites the header, and presents it one cycle later behind a valid/ready handshake.
- Adds a bypass mode and saturating per-channel hit/memory-redirect statistics counters.
- Sits between the directory lookup table and the router crossbar input stage.

Parameters:
- NUM_CH, 5, number of independent input channels.
- DEST_W, 8, destination address width.
- NHOP_W, 5, next-hop (one-hot port) width.
- RID_W, 8, router id width.
- TYPE_W, 3, packet type width.
- CNT_W, 16, statistics counter width.
- ROUTER_ID, 0, this router's id.
- NUM_COMPUTE_NODES, 16, offset of a router's home-memory address from its id.
- MEM_ADDRESS, 0, destination used on directory miss.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-low reset.
- bypass, in, 1, 1 = all channels pass headers unmodified (counters frozen).
- cnt_clr, in, 1, synchronous clear of all statistics counters.
- in_valid, in, NUM_CH, per-channel input valid.
- in_ready, out, NUM_CH, per-channel input ready.
- in_type, in, NUM_CH*TYPE_W, packet types.
- in_rid, in, NUM_CH*RID_W, originating router ids.
- in_dest, in, NUM_CH*DEST_W, original destinations.
- in_nhop, in, NUM_CH*NHOP_W, original next hops.
- dir_hit, in, NUM_CH, directory hit per channel.
- dir_dest, in, NUM_CH*DEST_W, directory owner address.
- dir_nhop, in, NUM_CH*NHOP_W, next hop toward the directory owner.
- mem_nhop, in, NUM_CH*NHOP_W, next hop toward MEM_ADDRESS.
- out_valid, out, NUM_CH, per-channel output valid.
- out_ready, in, NUM_CH, per-channel downstream ready.
- out_type, out, NUM_CH*TYPE_W, rewritten types.
- out_dest, out, NUM_CH*DEST_W, rewritten destinations.
- out_nhop, out, NUM_CH*NHOP_W, rewritten next hops.
- hit_cnt, out, NUM_CH*CNT_W, accepted redirect-to-directory count.
- mem_cnt, out, NUM_CH*CNT_W, accepted redirect-to-memory count.

Behaviour:
- Channel i uses slice i of every bus (LSB = channel 0). Channels are fully independent.
- Decode per channel, combinational on inputs:
  - OUTST = type==TYPE_OUTSTANDING && rid==ROUTER_ID && hit. Result: dest=in_dest, nhop=dir_nhop, type unchanged.
  - REDIR = type==TYPE_REQUEST && rid==ROUTER_ID && in_dest==ROUTER_ID+NUM_COMPUTE_NODES, with the sum truncated to DEST_W.
    - REDIR with hit: dest=dir_dest, nhop=dir_nhop, type=TYPE_C_REQ.
    - REDIR without hit: dest=MEM_ADDRESS, nhop=mem_nhop, type unchanged.
  - Otherwise, or when bypass=1: passthrough of type, dest and nhop.
  - OUTST is checked first; OUTST and REDIR are mutually exclusive by type.
- Handshake and pipeline, per channel:
  - One register stage; latency exactly 1 cycle from accept to out_valid.
  - in_ready = !out_valid || out_ready (combinational, no skid).
  - Accept when in_valid && in_ready: load the rewritten header and set out_valid=1.
  - When out_valid && out_ready && !in_valid, clear out_valid.
  - Output data holds stable while out_valid && !out_ready.
  - Back-to-back accept at full throughput is required when out_ready is held at 1.
- Counters:
  - On accept with bypass=0: REDIR&hit increments hit_cnt[i]; REDIR&!hit increments mem_cnt[i]; OUTST counts nothing.
  - Counters saturate at all-ones with no wrap.
  - cnt_clr has priority over a same-cycle increment (result 0).
- Reset (rst=0 at clk edge):
  - out_valid=0, out_type/out_dest/out_nhop=0, hit_cnt=mem_cnt=0.
  - in_ready is 1 during and immediately after reset (because out_valid=0).
  - Reset mid-transfer drops any held header; no replay.
- bypass is sampled at accept time; toggling it never affects a header already registered.

Decomposition:
- Shared package (noc_pkt): TYPE_REQUEST, TYPE_OUTSTANDING, TYPE_C_REQ encodings and default widths.
- Sub-module hitmux_lane: decode, pipeline register and two counters for one channel.
- Top level: generate loop over NUM_CH doing bus slicing only.

Test Plan:
- Reset and idle (ROUTER_ID=3): rst=0 for 2 cycles -> all outputs 0, in_ready all 1. Release rst; in_valid=0 -> out_valid stays 0.
- Redirect hit: ch0 REQUEST, rid=3, dest=19, hit=1, dir_dest=0x2A, dir_nhop=5'b00100 -> next cycle out_type=TYPE_C_REQ, dest=0x2A, nhop=00100; hit_cnt[0]=1.
- Redirect miss: same header with hit=0, MEM_ADDRESS=0, mem_nhop=5'b10000 -> dest=0, nhop=10000, type=REQUEST; mem_cnt[0]=1. Outstanding with rid=3, hit=1 -> dest unchanged, nhop=dir_nhop, no count change.
- Backpressure: ch2 out_ready=0 for 4 cycles with in_valid=1 -> in_ready[2]=0 and output stable. Ready returns -> one transfer per cycle, no loss or duplication. Other channels unaffected throughout.
- Bypass and non-matching: bypass=1 with REDIR header -> passthrough, counters unchanged. bypass=0 with rid=4 -> passthrough.
- Counter edges: CNT_W=4, 17 hits -> hit_cnt saturates at 15. cnt_clr coincident with a hit -> 0. Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 next cycle.
